// File: rtl/mux_rr_scheduler_if.sv
// Bus bundle for the round-robin mux scheduler: requests and data lanes in,
// grant, select and sampled output back.
interface mux_rr_scheduler_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] I;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       Y;
  logic       valid;

  modport master (output en, req, I, input gnt, S, Y, valid);
  modport slave  (input en, req, I, output gnt, S, Y, valid);
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing a 4:1 single-bit mux among four requesters;
// each grant yields at most BURST registered samples of the selected lane.
module mux_rr_scheduler #(
  parameter int unsigned BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_rr_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       valid;
  logic [3:0] cnt;
  logic [1:0] ptr;

  logic [1:0] rel_ptr;
  logic [1:0] win_idle;
  logic [1:0] win_rel;
  logic       any_req;
  logic       sample;
  logic       release_now;

  // First requesting lane scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    rel_ptr     = sel + 2'd1;
    any_req     = |bus.req;
    win_idle    = pick(ptr, bus.req);
    win_rel     = pick(rel_ptr, bus.req);
    sample      = 1'b0;
    release_now = 1'b0;
    if (!bus.en) begin
      release_now = 1'b1;
    end else if (!bus.req[sel]) begin
      release_now = 1'b1;
    end else if (cnt == 4'(BURST)) begin
      sample      = 1'b1;
      release_now = 1'b1;
    end else begin
      sample      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      y     <= 1'b0;
      valid <= 1'b0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (bus.en && any_req) begin
            gnt   <= 4'b0001 << win_idle;
            sel   <= win_idle;
            cnt   <= 4'd1;
            state <= GRANT;
          end
        end
        GRANT: begin
          valid <= sample;
          if (sample) y <= bus.I[sel];
          // Release re-arbitrates on the same edge from the lane after the
          // released one, so back-to-back grants have no bubble.
          if (release_now) begin
            ptr <= rel_ptr;
            if (bus.en && any_req) begin
              gnt <= 4'b0001 << win_rel;
              sel <= win_rel;
              cnt <= 4'd1;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt;
  assign bus.S     = sel;
  assign bus.Y     = y;
  assign bus.valid = valid;

endmodule
